// File: rtl/rib_timer_if.sv
// RIB slave-side bus bundle for rib_timer: request, write enable,
// address, write/read data, plus the timer-0 interrupt line.
interface rib_timer_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        int_sig_o;

   modport master (
      output req_i, we_i, addr_i, data_i,
      input  data_o, int_sig_o
   );

   modport slave (
      input  req_i, we_i, addr_i, data_i,
      output data_o, int_sig_o
   );
endinterface

// File: rtl/rib_timer.sv
// rib_timer: 32-bit memory-mapped compare timer with level interrupt.
// Ports: clk, rst (async active-low), bus (rib_timer_if.slave):
//   req_i/we_i/addr_i/data_i in, data_o (comb read), int_sig_o out.
// Regs: 0x0 CTRL{ONESHOT,PEND(W1C),IE,EN} 0x4 COUNT 0x8 VALUE
//   0xC PRESCALE (only with TINYRISCV_TIMER_PRESCALE_EN).
module rib_timer #(
   parameter logic [31:0] VALUE_RST = 32'hFFFF_FFFF,
   parameter int          PS_W      = 16
) (
   input logic       clk,
   input logic       rst,
   rib_timer_if.slave bus
);

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_CNT  = 2'd1;
   localparam logic [1:0] A_VAL  = 2'd2;
   localparam logic [1:0] A_PS   = 2'd3;

   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        pend_q, pend_d;
   logic        os_q, os_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] val_q, val_d;

   logic        wr, wr_ctrl, wr_cnt, wr_val;
   logic        term, tick, expire;
   logic [31:0] ps_rd;
   logic [31:0] rd;
   logic        unused;

   assign wr      = bus.req_i & bus.we_i;
   assign wr_ctrl = wr & (bus.addr_i[3:2] == A_CTRL);
   assign wr_cnt  = wr & (bus.addr_i[3:2] == A_CNT);
   assign wr_val  = wr & (bus.addr_i[3:2] == A_VAL);

   assign unused = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

`ifdef TINYRISCV_TIMER_PRESCALE_EN
   logic            wr_ps;
   logic [PS_W-1:0] ps_q, ps_d;
   logic [PS_W-1:0] psc_q, psc_d;

   assign wr_ps = wr & (bus.addr_i[3:2] == A_PS);
   assign term  = (psc_q == ps_q);
   assign ps_rd = 32'(ps_q);

   // Prescale counter only runs while enabled; a new
   // PRESCALE value restarts the period from zero.
   always_comb begin
      ps_d  = wr_ps ? bus.data_i[PS_W-1:0] : ps_q;
      psc_d = psc_q + PS_W'(1);
      if (!en_q || wr_ps || term)
         psc_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_q  <= '0;
         psc_q <= '0;
      end else begin
         ps_q  <= ps_d;
         psc_q <= psc_d;
      end
   end
`else
   logic [PS_W-1:0] ps_zero;

   assign ps_zero = '0;
   assign term    = 1'b1;
   assign ps_rd   = 32'(ps_zero);
`endif

   assign tick   = en_q & term;
   assign expire = tick & (val_q != 32'd0)
                 & (cnt_q >= val_q - 32'd1);

   always_comb begin
      en_d   = en_q;
      ie_d   = ie_q;
      os_d   = os_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;
      val_d  = val_q;
      if (wr_ctrl) begin
         en_d   = bus.data_i[0];
         ie_d   = bus.data_i[1];
         os_d   = bus.data_i[3];
         pend_d = pend_q & ~bus.data_i[2];
      end
      // Expiry beats a same-cycle W1C so no event is lost;
      // one-shot stop yields to an explicit EN=1 write.
      if (expire) begin
         pend_d = 1'b1;
         if (os_q && !(wr_ctrl && bus.data_i[0]))
            en_d = 1'b0;
      end
      if (wr_cnt)
         cnt_d = bus.data_i;
      else if (expire)
         cnt_d = 32'd0;
      else if (tick)
         cnt_d = cnt_q + 32'd1;
      if (wr_val)
         val_d = bus.data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q   <= 1'b0;
         ie_q   <= 1'b0;
         pend_q <= 1'b0;
         os_q   <= 1'b0;
         cnt_q  <= 32'd0;
         val_q  <= VALUE_RST;
      end else begin
         en_q   <= en_d;
         ie_q   <= ie_d;
         pend_q <= pend_d;
         os_q   <= os_d;
         cnt_q  <= cnt_d;
         val_q  <= val_d;
      end
   end

   always_comb begin
      rd = 32'd0;
      case (bus.addr_i[3:2])
         A_CTRL:  rd = {28'd0, os_q, pend_q, ie_q, en_q};
         A_CNT:   rd = cnt_q;
         A_VAL:   rd = val_q;
         A_PS:    rd = ps_rd;
         default: rd = 32'd0;
      endcase
   end

   assign bus.data_o    = bus.req_i ? rd : 32'd0;
   assign bus.int_sig_o = pend_q & ie_q;

endmodule

// File: doc/rib_timer.md
# rib_timer

Memory-mapped 32-bit timer that sits as a slave (responder) on the core's RIB bus and drives the timer-0 interrupt line into the core's interrupt controller. Software programs a compare value and control bits over RIB. The counter advances on each tick, and on expiry the block raises a level interrupt. Expiry code INT_TIMER0 is 8'b00000001, with vector entry 32'h4. The RIB master (core/bus arbiter) and the interrupt controller are the other ends of both of its interfaces.

## Interface
Parameters:
- `VALUE_RST`, 32'hFFFF_FFFF, reset value of the compare register.
- `PS_W`, 16, width of the prescale register. Only used with the configuration macro.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; asynchronous and active-low (`rst == 1'b0` resets the block).
- `req_i`  in  1  RIB request; 1 is RIB_REQ.
- `we_i`  in  1  write enable; 1 is WriteEnable.
- `addr_i`  in  32  byte address. Only `addr_i[3:2]` is decoded.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, combinational.
- `int_sig_o`  out  1  interrupt; 1 is INT_ASSERT.

## Operation
Register map (word offsets):
- **0x0 CTRL**
  - bit0 EN: counter enable.
  - bit1 IE: interrupt enable.
  - bit2 PEND: write-1-to-clear. Writing 0 to PEND leaves it unchanged.
  - bit3 ONESHOT.
  - Other bits read 0.
- **0x4 COUNT**: read/write.
- **0x8 VALUE**: compare value, read/write.
- **0xC PRESCALE**: see Configuration.

Tick and expiry:
- tick = EN && prescaler terminal.
- Without the macro, the prescaler terminal is always 1.
- On a tick with VALUE != 0 and COUNT >= VALUE-1 (expiry):
  - COUNT <= 0.
  - PEND <= 1.
  - If ONESHOT, EN <= 0.
- Any other tick: COUNT <= COUNT+1, wrapping 32'hFFFF_FFFF -> 0.
- VALUE == 0: counter free-runs and never expires.
- The expiry period is VALUE ticks. If VALUE is lowered below COUNT, the next tick expires.

Outputs and bus rules:
- `int_sig_o = PEND & IE`, driven from registers.
- Reads:
  - `data_o` = selected register when `req_i`, else 0.
  - Unmapped bits and undecoded registers read 0.
- Writes take effect at the `clk` edge where `req_i && we_i`.
- There is no wait state. Every access completes in its own cycle.

## Timing
Reset values:
- CTRL = 0.
- COUNT = 0.
- VALUE = `VALUE_RST`.
- PRESCALE = 0, prescale counter = 0.
- `int_sig_o` = 0.
- `data_o` = 0, since `req_i` is low.

Latency:
- A write of EN=1 at edge N gives the first tick at edge N+1, so COUNT = 1 after N+1.
- `int_sig_o` rises in the cycle after the expiry edge.
- A W1C write to PEND drops `int_sig_o` in the cycle after the write edge.

Simultaneous events, all decided against the pre-edge state:
- Expiry and W1C of PEND in the same cycle: the set wins and PEND stays 1, so no event is lost.
- Software write to COUNT in the same cycle as a tick: the software value wins, with no increment.
- Software write to CTRL in the same cycle as expiry:
  - EN/IE/ONESHOT take the written values.
  - PEND is still set.
  - The ONESHOT clear of EN applies only if software did not write EN=1.
- Clearing EN freezes COUNT and PEND.
- Reset mid-count returns all state to reset values immediately (asynchronous). The first post-reset tick requires a new EN write.

## Configuration
- `TINYRISCV_TIMER_PRESCALE_EN` defined:
  - PRESCALE (0xC) is a `PS_W`-bit read/write register, zero-extended on read.
  - An internal prescale counter increments each clock while EN=1.
  - The terminal fires when the counter equals PRESCALE; the counter then returns to 0. This gives one tick every PRESCALE+1 clocks.
  - The prescale counter clears when EN is 0, and on any PRESCALE write.
- Macro undefined:
  - Tick on every enabled clock.
  - 0xC reads 0 and ignores writes.
  - No prescale flops exist.

## Test plan
1. **Reset values.** Hold `rst`=0 for 3 clocks with `req_i`=1 and addr 0x8 -> `data_o`=32'hFFFF_FFFF. CTRL and COUNT read 0; `int_sig_o`=0.
2. **Periodic expiry.** Write VALUE=5, then CTRL=32'h3 -> COUNT reads 1,2,3,4,0. `int_sig_o` rises 1 cycle after the 5th tick. W1C 32'h7 drops it next cycle, and the block re-expires 5 ticks later.
3. **One-shot.** Write VALUE=3, then CTRL=32'hB -> one expiry. EN reads 0 and COUNT holds 0 for 10 following cycles.
4. **Simultaneous events.**
   - W1C PEND on the expiry cycle -> PEND=1 remains.
   - Write COUNT=100 on a tick cycle -> reads 100.
5. **Edge values.**
   - VALUE=0, COUNT=32'hFFFF_FFFE, EN=1 -> COUNT reads FFFF_FFFF, then 0. No interrupt.
   - Set VALUE=2 while COUNT=7 -> expiry on the next tick.
6. **Macro-dependent behaviour.**
   - With `TINYRISCV_TIMER_PRESCALE_EN`: PRESCALE=3, VALUE=2 -> `int_sig_o` rises 8 clocks after EN. `rst` low mid-count -> all state back to reset values.
   - Without the macro: 0xC reads 0 after a write of 32'h3.
